piso_shift_register: RTL and testbench

Parallel-in serial-out shift register, the transmit-side counterpart of sipo_shift_register. It accepts a WIDTH-bit word through a valid/ready load handshake and emits it one bit per clock on serial_out, qualified by serial_valid. A done pulse marks the last bit. It is intended to drive sipo_shift_register.serial_in directly for serial links and loopback tests.

---
 rtl/shift_pkg.sv | 25 ++
 rtl/shift_bit_counter.sv | 33 +++
 rtl/piso_shift_register.sv | 126 ++++++++++++
 tb/tb_piso_shift_register.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift-register family (PISO/SIPO).
// Holds state encodings, the counter-width helper and the default word width.
package shift_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    // Ceiling log2; returns at least 1 so a counter always has one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Bit counter for the shift FSM: synchronous clear on load, count on enable,
// wraps after WIDTH-1 and flags the terminal count.
module shift_bit_counter
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned CW = clog2(WIDTH);

    logic [CW-1:0] r_count;
    logic          w_tc;

    assign w_tc = (r_count == CW'(WIDTH - 1));
    assign o_tc = w_tc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_tc ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shift register with valid/ready load handshake.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_shift_register
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_shift;
    logic             r_serial_out;
    logic             w_load_ready;
    logic             w_accept;
    logic             w_tc;
    logic             w_first_bit;
    logic             w_head;
    logic [WIDTH-1:0] w_load_rest;
    logic [WIDTH-1:0] w_shifted;
`ifdef PISO_PARITY_EN
    logic             r_parity;
`endif

    shift_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_accept),
        .i_en   (r_state == ST_SHIFT),
        .o_tc   (w_tc)
    );

    // r_shift holds only the bits still to be sent; the bit on the wire lives in r_serial_out.
    assign w_first_bit = MSB_FIRST ? parallel_in[WIDTH-1] : parallel_in[0];
    assign w_load_rest = MSB_FIRST ? {parallel_in[WIDTH-2:0], 1'b0} : {1'b0, parallel_in[WIDTH-1:1]};
    assign w_head      = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign w_shifted   = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};

`ifdef PISO_PARITY_EN
    assign w_load_ready = (r_state == ST_IDLE) | (r_state == ST_PAR);
    assign done         = (r_state == ST_PAR);
`else
    assign w_load_ready = (r_state == ST_IDLE) | ((r_state == ST_SHIFT) & w_tc);
    assign done         = (r_state == ST_SHIFT) & w_tc;
`endif

    assign w_accept     = load_valid & w_load_ready;
    assign load_ready   = w_load_ready;
    assign serial_valid = (r_state != ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign serial_out   = r_serial_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_tc) begin
`ifdef PISO_PARITY_EN
                    w_next_state = ST_PAR;
`else
                    w_next_state = w_accept ? ST_SHIFT : ST_IDLE;
`endif
                end
            end
            ST_PAR: begin
                w_next_state = w_accept ? ST_SHIFT : ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift      <= '0;
            r_serial_out <= 1'b0;
`ifdef PISO_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else if (w_accept) begin
            r_shift      <= w_load_rest;
            r_serial_out <= w_first_bit;
`ifdef PISO_PARITY_EN
            r_parity     <= ^parallel_in;
`endif
        end else if ((r_state == ST_SHIFT) && !w_tc) begin
            r_shift      <= w_shifted;
            r_serial_out <= w_head;
        end else if ((r_state == ST_SHIFT) && w_tc) begin
            r_shift      <= '0;
`ifdef PISO_PARITY_EN
            r_serial_out <= r_parity;
`else
            r_serial_out <= 1'b0;
`endif
        end else begin
            r_shift      <= '0;
            r_serial_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed self-checking bench for piso_shift_register (WIDTH=4, both bit orders).
module tb_piso_shift_register;

`ifdef PISO_PARITY_EN
    localparam int L = 5;
`else
    localparam int L = 4;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [3:0] parallel_in;

    logic m_load_ready, m_serial_out, m_serial_valid, m_busy, m_done;
    logic l_load_ready, l_serial_out, l_serial_valid, l_busy, l_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    piso_shift_register #(
        .WIDTH     (4),
        .MSB_FIRST (1'b1)
    ) dut_msb (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (m_load_ready),
        .parallel_in  (parallel_in),
        .serial_out   (m_serial_out),
        .serial_valid (m_serial_valid),
        .busy         (m_busy),
        .done         (m_done)
    );

    piso_shift_register #(
        .WIDTH     (4),
        .MSB_FIRST (1'b0)
    ) dut_lsb (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (l_load_ready),
        .parallel_in  (parallel_in),
        .serial_out   (l_serial_out),
        .serial_valid (l_serial_valid),
        .busy         (l_busy),
        .done         (l_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; load_valid = 1'b1; parallel_in = 4'hF;
        tick(); tick();
        n_checks++; if ({m_serial_valid, m_serial_out, m_done, m_busy, m_load_ready} !== 5'b00001) begin
            n_errors++; $display("FAIL reset_msb: got %b expected 00001", {m_serial_valid, m_serial_out, m_done, m_busy, m_load_ready});
        end
        n_checks++; if ({l_serial_valid, l_serial_out, l_done, l_busy, l_load_ready} !== 5'b00001) begin
            n_errors++; $display("FAIL reset_lsb: got %b expected 00001", {l_serial_valid, l_serial_out, l_done, l_busy, l_load_ready});
        end
        load_valid = 1'b0;
        reset = 1'b1;
        tick();
        n_checks++; if (m_serial_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_no_capture: serial_valid got %b expected 0", m_serial_valid);
        end
    endtask

    task automatic test_single_word;
        logic [L-1:0] exp_m, exp_l, exp_d;
`ifdef PISO_PARITY_EN
        exp_m = 5'b10111; exp_l = 5'b11011; exp_d = 5'b00001;
`else
        exp_m = 4'b1011;  exp_l = 4'b1101;  exp_d = 4'b0001;
`endif
        load_valid = 1'b1; parallel_in = 4'b1011;
        tick();
        load_valid = 1'b0; parallel_in = 4'h0;
        for (int i = 0; i < L; i++) begin
            n_checks++; if ({m_serial_valid, m_serial_out, m_done} !== {1'b1, exp_m[L-1-i], exp_d[L-1-i]}) begin
                n_errors++; $display("FAIL single_msb bit %0d: got v/o/d %b expected %b", i, {m_serial_valid, m_serial_out, m_done}, {1'b1, exp_m[L-1-i], exp_d[L-1-i]});
            end
            n_checks++; if ({l_serial_valid, l_serial_out, l_done} !== {1'b1, exp_l[L-1-i], exp_d[L-1-i]}) begin
                n_errors++; $display("FAIL single_lsb bit %0d: got v/o/d %b expected %b", i, {l_serial_valid, l_serial_out, l_done}, {1'b1, exp_l[L-1-i], exp_d[L-1-i]});
            end
            tick();
        end
        n_checks++; if ({m_serial_valid, m_serial_out, m_busy, m_done, m_load_ready} !== 5'b00001) begin
            n_errors++; $display("FAIL single_idle: got %b expected 00001", {m_serial_valid, m_serial_out, m_busy, m_done, m_load_ready});
        end
    endtask

    task automatic test_back_to_back;
        logic [2*L-1:0] exp_s, exp_d;
`ifdef PISO_PARITY_EN
        exp_s = 10'b10100_01010; exp_d = 10'b00001_00001;
`else
        exp_s = 8'b1010_0101;    exp_d = 8'b0001_0001;
`endif
        load_valid = 1'b1; parallel_in = 4'hA;
        tick();
        parallel_in = 4'h5;
        for (int i = 0; i < 2*L; i++) begin
            n_checks++; if ({m_serial_valid, m_serial_out, m_done} !== {1'b1, exp_s[2*L-1-i], exp_d[2*L-1-i]}) begin
                n_errors++; $display("FAIL b2b cycle %0d: got v/o/d %b expected %b", i + 1, {m_serial_valid, m_serial_out, m_done}, {1'b1, exp_s[2*L-1-i], exp_d[2*L-1-i]});
            end
            if (i == 1) begin
                n_checks++; if (m_load_ready !== 1'b0) begin
                    n_errors++; $display("FAIL b2b ready_mid: got %b expected 0", m_load_ready);
                end
            end
            if (i == L-1) begin
                n_checks++; if (m_load_ready !== 1'b1) begin
                    n_errors++; $display("FAIL b2b ready_last: got %b expected 1", m_load_ready);
                end
            end
            if (i == L) load_valid = 1'b0;
            tick();
        end
        n_checks++; if ({m_serial_valid, m_serial_out, m_busy} !== 3'b000) begin
            n_errors++; $display("FAIL b2b_idle: got %b expected 000", {m_serial_valid, m_serial_out, m_busy});
        end
    endtask

    task automatic test_reset_mid_word;
        logic [L-1:0] exp_m, exp_d;
`ifdef PISO_PARITY_EN
        exp_m = 5'b00110; exp_d = 5'b00001;
`else
        exp_m = 4'b0011;  exp_d = 4'b0001;
`endif
        load_valid = 1'b1; parallel_in = 4'hF;
        tick();
        load_valid = 1'b0;
        tick();
        n_checks++; if ({m_serial_valid, m_serial_out} !== 2'b11) begin
            n_errors++; $display("FAIL mid_before_reset: got %b expected 11", {m_serial_valid, m_serial_out});
        end
        #2 reset = 1'b0;
        #1;
        n_checks++; if ({m_serial_valid, m_serial_out, m_busy, m_done, m_load_ready} !== 5'b00001) begin
            n_errors++; $display("FAIL mid_async_clear: got %b expected 00001", {m_serial_valid, m_serial_out, m_busy, m_done, m_load_ready});
        end
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if ({m_serial_valid, m_done} !== 2'b00) begin
            n_errors++; $display("FAIL mid_after_release: got %b expected 00", {m_serial_valid, m_done});
        end
        load_valid = 1'b1; parallel_in = 4'h3;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < L; i++) begin
            n_checks++; if ({m_serial_valid, m_serial_out, m_done} !== {1'b1, exp_m[L-1-i], exp_d[L-1-i]}) begin
                n_errors++; $display("FAIL mid_reload bit %0d: got v/o/d %b expected %b", i, {m_serial_valid, m_serial_out, m_done}, {1'b1, exp_m[L-1-i], exp_d[L-1-i]});
            end
            tick();
        end
    endtask

    task automatic test_loopback;
        logic [3:0] sipo;
        int         nbits;
        int         done_at;
        sipo = 4'h0; nbits = 0; done_at = -1;
        load_valid = 1'b1; parallel_in = 4'h9;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < L + 2; i++) begin
            if (m_done) done_at = i;
            if (m_serial_valid && nbits < 4) begin
                sipo  = {sipo[2:0], m_serial_out};
                nbits = nbits + 1;
            end
            tick();
        end
        n_checks++; if (done_at !== L-1) begin
            n_errors++; $display("FAIL loopback_done_cycle: got %0d expected %0d", done_at, L-1);
        end
        n_checks++; if (sipo !== 4'h9) begin
            n_errors++; $display("FAIL loopback_word: got %h expected 9", sipo);
        end
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity;
        logic [4:0] exp_m;
        exp_m = 5'b01111;
        load_valid = 1'b1; parallel_in = 4'h7;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if ({m_serial_valid, m_serial_out, m_done} !== {1'b1, exp_m[4-i], (i == 4)}) begin
                n_errors++; $display("FAIL parity bit %0d: got v/o/d %b expected %b", i, {m_serial_valid, m_serial_out, m_done}, {1'b1, exp_m[4-i], (i == 4)});
            end
            tick();
        end
        n_checks++; if (m_serial_valid !== 1'b0) begin
            n_errors++; $display("FAIL parity_idle: got %b expected 0", m_serial_valid);
        end
    endtask
`endif

    initial begin
        reset = 1'b0; load_valid = 1'b0; parallel_in = 4'h0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_reset_mid_word();
        test_loopback();
`ifdef PISO_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
